// File: rtl/chicken_pkg.sv
// Shared definitions for the chicken race turn sequencer: state codes,
// player-count decode, start tiles and the ring increment helper.
package chicken_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        WAIT_GO = 3'b001,
        FETCH   = 3'b010,
        COMPARE = 3'b011,
        MOVE    = 3'b100,
        PASS    = 3'b101,
        HANDOFF = 3'b110,
        WIN     = 3'b111
    } state_t;

    localparam int NUM_PLAYERS = 4;

    // Code 11 is not a legal count; it behaves like a four-player game.
    function automatic logic [2:0] player_count(input logic [1:0] n);
        case (n)
            2'b00:   return 3'd2;
            2'b01:   return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [4:0] start_tile(input logic [1:0] idx);
        case (idx)
            2'd0:    return 5'd0;
            2'd1:    return 5'd6;
            2'd2:    return 5'd12;
            default: return 5'd18;
        endcase
    endfunction

    function automatic logic [4:0] wrap_inc(input logic [4:0] p, input logic [4:0] last);
        return (p == last) ? 5'd0 : p + 5'd1;
    endfunction

endpackage

// File: rtl/chicken_pos_regs.sv
// Per-player ring position and step counters with a single write port
// selected by the current player index.
module chicken_pos_regs
    import chicken_pkg::*;
#(
    parameter int BOARD_LEN = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [1:0]      idx,
    output logic [3:0][4:0] pos,
    output logic [3:0][4:0] steps
);

    localparam logic [4:0] LAST_TILE = 5'(BOARD_LEN - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                pos[i]   <= start_tile(2'(i));
                steps[i] <= '0;
            end
        end else if (we) begin
            pos[idx]   <= wrap_inc(pos[idx], LAST_TILE);
            steps[idx] <= steps[idx] + 5'd1;
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer: flips a card, looks up the tile ahead of the current
// chicken, and either steps it forward or hands the turn to the next player.
module turn_sequencer
    import chicken_pkg::*;
#(
    parameter int BOARD_LEN = 24,
    parameter int LAP_STEPS = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] N,
    input  logic [1:0] turn,
    input  logic       go,
    input  logic [3:0] card_id,
    output logic [4:0] tile_addr,
    input  logic [3:0] tile_id,
    output logic [2:0] Q,
    output logic       statecombo_next_turn,
    output logic       move_fwd,
    output logic [4:0] pos0,
    output logic [4:0] pos1,
    output logic [4:0] pos2,
    output logic [4:0] pos3,
    output logic       winner_valid,
    output logic [1:0] winner
);

    localparam logic [4:0] LAST_TILE = 5'(BOARD_LEN - 1);
    localparam logic [4:0] LAP       = 5'(LAP_STEPS);

    state_t          state, state_nxt;
    logic [3:0]      card_q;
    logic [1:0]      pidx;
    logic [3:0][4:0] pos, steps;
    logic [4:0]      step_nxt;
    logic            pos_we;

    // Out-of-range turn values fall back to player 0, so unused slots never move.
    assign pidx     = ({1'b0, turn} >= player_count(N)) ? 2'd0 : turn;
    assign step_nxt = steps[pidx] + 5'd1;

    chicken_pos_regs #(.BOARD_LEN(BOARD_LEN)) u_pos_regs (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (pos_we),
        .idx   (pidx),
        .pos   (pos),
        .steps (steps)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt            = state;
        move_fwd             = 1'b0;
        statecombo_next_turn = 1'b0;
        pos_we               = 1'b0;
        unique case (state)
            IDLE:    state_nxt = WAIT_GO;
            WAIT_GO: if (go) state_nxt = FETCH;
            FETCH:   state_nxt = COMPARE;
            COMPARE: state_nxt = (card_q == tile_id) ? MOVE : PASS;
            MOVE: begin
                move_fwd  = 1'b1;
                pos_we    = 1'b1;
                state_nxt = (step_nxt == LAP) ? WIN : WAIT_GO;
            end
            PASS:    state_nxt = HANDOFF;
            HANDOFF: begin
                statecombo_next_turn = 1'b1;
                state_nxt            = WAIT_GO;
            end
            WIN:     state_nxt = WIN;
        endcase
    end

    // The ROM address is registered on the go pulse so it is stable for the
    // whole FETCH/COMPARE window and the ROM data lines up with COMPARE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            card_q       <= '0;
            tile_addr    <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
        end else begin
            if (state == WAIT_GO && go) begin
                card_q    <= card_id;
                tile_addr <= wrap_inc(pos[pidx], LAST_TILE);
            end
            if (state == MOVE && state_nxt == WIN) begin
                winner       <= pidx;
                winner_valid <= 1'b1;
            end
        end
    end

    assign Q    = state;
    assign pos0 = pos[0];
    assign pos1 = pos[1];
    assign pos2 = pos[2];
    assign pos3 = pos[3];

endmodule

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 SHALL have parameter BOARD_LEN, default 24, giving the number of ring tiles.
REQ-002 SHALL have parameter LAP_STEPS, default 24, giving the forward moves a chicken needs to win.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port N, input, 2 bits: player count code; 00=2, 01=3, 10=4, 11 treated as 4.
REQ-006 SHALL have port turn, input, 2 bits: current player index, driven by the next_turn stage.
REQ-007 SHALL have port go, input, 1 bit: debounced one-cycle pulse that flips the selected card.
REQ-008 SHALL have port card_id, input, 4 bits: picture of the selected card, valid when go=1.
REQ-009 SHALL have port tile_addr, output, 5 bits: ring tile address sent to the board ROM.
REQ-010 SHALL have port tile_id, input, 4 bits: ROM picture, valid one cycle after tile_addr.
REQ-011 SHALL have port Q, output, 3 bits: current FSM state encoding.
REQ-012 SHALL have port statecombo_next_turn, output, 1 bit: one-cycle pulse telling next_turn to advance.
REQ-013 SHALL have port move_fwd, output, 1 bit: one-cycle pulse on each successful chicken step.
REQ-014 SHALL have port pos0..pos3, output, 5 bits each: chicken tile positions.
REQ-015 SHALL have port winner_valid, output, 1 bit, and winner, output, 2 bits: winner flag and winning player index.

Function
REQ-016 SHALL implement states IDLE=000, WAIT_GO=001, FETCH=010, COMPARE=011, MOVE=100, PASS=101, HANDOFF=110, WIN=111, with Q driven directly from the state register.
REQ-017 SHALL go from IDLE to WAIT_GO one cycle after reset release.
REQ-018 SHALL, in WAIT_GO, ignore all inputs until go=1, then latch card_id and go to FETCH.
REQ-019 SHALL, in FETCH, drive tile_addr=(pos[turn]+1) mod BOARD_LEN and go to COMPARE next cycle; tile_addr SHALL hold its value through COMPARE.
REQ-020 SHALL, in COMPARE, go to MOVE if latched card equals tile_id, else to PASS.
REQ-021 SHALL, in MOVE, increment pos[turn] with wrap from BOARD_LEN-1 to 0, increment that player's 5-bit step count, and pulse move_fwd for one cycle.
REQ-022 SHALL go from MOVE to WIN when the new step count equals LAP_STEPS, else to WAIT_GO so the same player flips again.
REQ-023 SHALL go from PASS to HANDOFF unconditionally after one cycle.
REQ-024 SHALL assert statecombo_next_turn only during the single HANDOFF cycle, then go to WAIT_GO.
REQ-025 SHALL ignore a go pulse arriving in any state other than WAIT_GO; it SHALL NOT be queued.
REQ-026 SHALL treat a turn value at or above the player count as player 0 for indexing.
REQ-027 SHALL latch winner=turn and set winner_valid=1 on entry to WIN, and hold them until reset.
REQ-028 SHALL keep WIN absorbing, with no further outputs pulsed.
REQ-029 SHALL give positions for unused players (index >= player count) no update.

Reset
REQ-030 SHALL, while rst_n=0, force state IDLE and set Q=000, tile_addr=0, statecombo_next_turn=0, move_fwd=0, winner_valid=0, winner=0, and latched card=0.
REQ-031 SHALL, while rst_n=0, initialise positions to start tiles pos0=0, pos1=6, pos2=12, pos3=18 and clear all step counts.
REQ-032 SHALL have a reset asserted mid-turn abort the turn immediately with no pulse emitted.

Structure
REQ-033 SHALL place state encodings, player-count decode, and start-tile constants in shared package chicken_pkg.
REQ-034 SHALL implement player position and step storage as sub-module chicken_pos_regs (4 entries, write port indexed by turn).

Verification
REQ-035 SHALL show: reset, N=00 -> Q=000, then 001 next cycle; pos0=0, pos1=6.
REQ-036 SHALL show: go with card_id=5, tile_id=5 at addr 1 -> tile_addr=1 in FETCH, move_fwd pulse, pos0=1, Q returns 001, no next_turn pulse.
REQ-037 SHALL show: go with card_id=5, tile_id=7 -> PASS then HANDOFF; statecombo_next_turn high exactly one cycle; pos unchanged.
REQ-038 SHALL show: pos3=23 and a match -> pos3 wraps to 0.
REQ-039 SHALL show: 24 consecutive matches for player 1 -> Q=111, winner_valid=1, winner=01; later go pulses produce no change.
REQ-040 SHALL show: go pulse during FETCH is ignored, and rst_n low during MOVE -> no move_fwd pulse and positions return to start values.
